// File: rtl/data_display_pkg.sv
// data_display_pkg: digit count and active-low {g,f,e,d,c,b,a} hex segment codes.
package data_display_pkg;
    localparam int DIGITS = 4;
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;
    localparam logic [6:0] SEG_TAB [16] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
                                            SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F};

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        return SEG_TAB[h];
    endfunction
endpackage

// File: rtl/data_sync_filter.sv
// data_sync_filter: two-flop synchronizer plus stability filter; flags a settled value differing from hist0_i.
module data_sync_filter #(
    parameter int STABLE_CYC = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] data_i,
    input  logic [3:0] hist0_i,
    output logic       accept_o,
    output logic [3:0] value_o
);
    localparam int CW = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC - 1);

    logic [3:0] s1_q, s2_q, cand_q;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (s2_q != cand_q) ? '0 : (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q   <= '0;
            s2_q   <= '0;
            cand_q <= '0;
            cnt_q  <= '0;
        end else begin
            s1_q   <= data_i;
            s2_q   <= s1_q;
            cand_q <= s2_q;
            cnt_q  <= cnt_d;
        end
    end

    // comparing against hist0 keeps a held value from re-triggering
    assign accept_o = (s2_q == cand_q) && (cnt_q == CNT_MAX) && (cand_q != hist0_i);
    assign value_o  = cand_q;
endmodule

// File: rtl/data_display_scanner.sv
// data_display_scanner: keeps a 4-deep history of filtered data values and scans it
// onto a multiplexed active-low 7-segment display, newest value on digit 0.
module data_display_scanner
    import data_display_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int STABLE_CYC = 4
) (
    input  logic       sysClk,
    input  logic       sysRst,
    input  logic [3:0] data,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic [7:0] changeCount,
    output logic       newData
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(DIGITS);
    localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);

    logic                   accept;
    logic [3:0]             value;
    logic [DIGITS-1:0][3:0] hist_q, hist_d;
    logic [PW-1:0]          pre_q, pre_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [7:0]             cc_q, cc_d;
    logic [6:0]             seg_q, seg_d;
    logic [DIGITS-1:0]      an_q, an_d;
    logic                   nd_q;

    data_sync_filter #(.STABLE_CYC(STABLE_CYC)) u_filter (
        .clk_i   (sysClk),
        .rst_i   (sysRst),
        .data_i  (data),
        .hist0_i (hist_q[0]),
        .accept_o(accept),
        .value_o (value)
    );

    always_comb begin
        hist_d = accept ? {hist_q[DIGITS-2:0], value} : hist_q;
        cc_d   = accept ? cc_q + 8'd1 : cc_q;
        pre_d  = (pre_q == PRE_MAX) ? '0 : pre_q + 1'b1;
        idx_d  = (pre_q == PRE_MAX) ? idx_q + 1'b1 : idx_q;
        an_d   = ~(DIGITS'(1) << idx_q);
        seg_d  = hex_to_seg(hist_q[idx_q]);
    end

    always_ff @(posedge sysClk) begin
        if (sysRst) begin
            hist_q <= '0;
            cc_q   <= '0;
            pre_q  <= '0;
            idx_q  <= '0;
            an_q   <= DIGITS'(4'b1110);
            seg_q  <= SEG_0;
            nd_q   <= 1'b0;
        end else begin
            hist_q <= hist_d;
            cc_q   <= cc_d;
            pre_q  <= pre_d;
            idx_q  <= idx_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            nd_q   <= accept;
        end
    end

    assign seg         = seg_q;
    assign an          = an_q;
    assign changeCount = cc_q;
    assign newData     = nd_q;
endmodule

// File: tb/tb_data_display_scanner.sv
// tb_data_display_scanner: directed vector table plus hand-written reset, latency, glitch and wrap sequences.
module tb_data_display_scanner;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] data = 4'h0;
    logic [6:0] seg;
    logic [3:0] an;
    logic [7:0] cc;
    logic       nd;
    int checks = 0;
    int errors = 0;
    int pulses = 0;

    data_display_scanner #(.SCAN_DIV(4), .STABLE_CYC(4)) dut (
        .sysClk     (clk),
        .sysRst     (rst),
        .data       (data),
        .seg        (seg),
        .an         (an),
        .changeCount(cc),
        .newData    (nd)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (nd) pulses++;

    typedef struct {
        logic [3:0] din;
        int         exp_pulses;
        logic [7:0] exp_cc;
        logic [6:0] exp_seg0;
    } vec_t;
    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_an(input logic [3:0] want, output bit ok);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = (an == want);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        data = 4'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_digit(input string name, input logic [3:0] want_an, input logic [6:0] exp_seg);
        bit ok;
        wait_an(want_an, ok);
        chk({name, "_an_seen"}, ok, 1);
        if (ok) chk(name, seg, exp_seg);
    endtask

    initial begin
        int p0;
        tbl[0]  = '{4'h1, 1, 8'd1,  7'b1111001};
        tbl[1]  = '{4'h2, 1, 8'd2,  7'b0100100};
        tbl[2]  = '{4'h3, 1, 8'd3,  7'b0110000};
        tbl[3]  = '{4'h4, 1, 8'd4,  7'b0011001};
        tbl[4]  = '{4'h5, 1, 8'd5,  7'b0010010};
        tbl[5]  = '{4'h5, 0, 8'd5,  7'b0010010};
        tbl[6]  = '{4'h0, 1, 8'd6,  7'b1000000};
        tbl[7]  = '{4'h6, 1, 8'd7,  7'b0000010};
        tbl[8]  = '{4'h7, 1, 8'd8,  7'b1111000};
        tbl[9]  = '{4'h8, 1, 8'd9,  7'b0000000};
        tbl[10] = '{4'h9, 1, 8'd10, 7'b0010000};
        tbl[11] = '{4'hA, 1, 8'd11, 7'b0001000};
        tbl[12] = '{4'hB, 1, 8'd12, 7'b0000011};
        tbl[13] = '{4'hC, 1, 8'd13, 7'b1000110};
        tbl[14] = '{4'hD, 1, 8'd14, 7'b0100001};
        tbl[15] = '{4'hE, 1, 8'd15, 7'b0000110};

        // reset values and scan stepping
        do_reset();
        chk("rst_an", an, 4'b1110);
        chk("rst_seg", seg, 7'b1000000);
        chk("rst_cc", cc, 8'd0);
        chk("rst_nd", nd, 1'b0);
        repeat (5) @(negedge clk);
        chk("scan_an1", an, 4'b1101);
        repeat (4) @(negedge clk);
        chk("scan_an2", an, 4'b1011);
        repeat (4) @(negedge clk);
        chk("scan_an3", an, 4'b0111);
        repeat (4) @(negedge clk);
        chk("scan_an0", an, 4'b1110);
        chk("rst_no_pulse", pulses, 0);

        // single change: pulse exactly after edge k+6
        data = 4'h3;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk($sformatf("lat_nd_%0d", i), nd, (i == 7) ? 1 : 0);
        end
        chk("single_cc", cc, 8'd1);
        check_digit("single_seg0", 4'b1110, 7'b0110000);

        // glitch of three cycles then back to the accepted value
        p0 = pulses;
        data = 4'h5;
        repeat (3) @(negedge clk);
        data = 4'h3;
        repeat (15) @(negedge clk);
        chk("glitch_pulses", pulses - p0, 0);
        chk("glitch_cc", cc, 8'd1);

        // table-driven sequence from a fresh reset
        do_reset();
        repeat (10) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            p0 = pulses;
            data = tbl[i].din;
            repeat (10) @(negedge clk);
            chk($sformatf("vec%0d_pulses", i), pulses - p0, tbl[i].exp_pulses);
            chk($sformatf("vec%0d_cc", i), cc, tbl[i].exp_cc);
            check_digit($sformatf("vec%0d_seg0", i), 4'b1110, tbl[i].exp_seg0);
            if (i == 4) begin
                check_digit("seq_d1", 4'b1101, 7'b0011001);
                check_digit("seq_d2", 4'b1011, 7'b0110000);
                check_digit("seq_d3", 4'b0111, 7'b0100100);
                check_digit("seq_d0", 4'b1110, 7'b0010010);
            end
        end

        // 256 alternating accepted changes wrap the counter
        do_reset();
        repeat (4) @(negedge clk);
        p0 = pulses;
        for (int i = 0; i < 256; i++) begin
            int w;
            if (i == 255) chk("wrap_cc_255", cc, 8'd255);
            w = pulses;
            data = (i % 2 == 0) ? 4'h1 : 4'h2;
            repeat (8) @(negedge clk);
            if (i == 255) chk("wrap_last_pulse", pulses - w, 1);
        end
        chk("wrap_total", pulses - p0, 256);
        chk("wrap_cc", cc, 8'd0);

        // reset inside the stability window
        repeat (4) @(negedge clk);
        p0 = pulses;
        data = 4'h7;
        repeat (2) @(negedge clk);
        do_reset();
        chk("mid_an", an, 4'b1110);
        chk("mid_seg", seg, 7'b1000000);
        chk("mid_cc", cc, 8'd0);
        chk("mid_nd", nd, 1'b0);
        repeat (12) @(negedge clk);
        chk("mid_pulses", pulses - p0, 0);
        chk("mid_cc_after", cc, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_display_scanner.md
# data_display_scanner

Consumer end of the key-driven 4-bit data generator. It samples the generator's asynchronous `data` bus into the system clock domain and accepts a new value only after it has been stable for a set time. It keeps a 4-deep history of accepted values and drives a time-multiplexed 4-digit active-low 7-segment display (digit 0 = newest). It also counts accepted changes and pulses once per acceptance.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each digit is enabled; legal ≥ 2.
- `STABLE_CYC`, default 4: consecutive equal synchronized samples required before acceptance; legal ≥ 1.
- `sysClk` input, 1: system clock; all state on rising edge.
- `sysRst` input, 1: reset, synchronous, active-high.
- `data` input, 4: value from the generator; asynchronous to `sysClk`; bits may skew.
- `seg` output, 7: segments `{g,f,e,d,c,b,a}`, active-low, registered.
- `an` output, 4: digit enables, active-low one-hot, registered.
- `changeCount` output, 8: number of accepted changes, wraps modulo 256.
- `newData` output, 1: one-cycle pulse on each acceptance.

## Operation
- **Synchronizer:** `data` passes through two flops, `s1` then `s2`.
- **Stability filter:** registers `cand` (4 bits) and `cnt`.
  - `s2 != cand`: load `cand <= s2` and `cnt <= 0`.
  - Otherwise `cnt` increments, saturating at `STABLE_CYC-1`.
- **Acceptance:** when `s2 == cand`, `cnt == STABLE_CYC-1` and `cand != hist[0]`:
  - shift `hist[3] <= hist[2]`, `hist[2] <= hist[1]`, `hist[1] <= hist[0]`, `hist[0] <= cand`;
  - `changeCount` +1;
  - `newData` = 1 for that cycle.
  - A value equal to `hist[0]` is never accepted, so holding a value produces no repeat pulses.
- **Scanner:**
  - Prescaler counts 0..`SCAN_DIV-1`.
  - At terminal count, digit index advances 0→1→2→3→0.
  - `an` = ~(1 << index).
  - `seg` = hex encoding of `hist[index]`.
- **Hex encoding, active-low:** 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- **Reset values:**
  - `s1`, `s2`, `cand`, `cnt`, all `hist`, prescaler, index, `changeCount` = 0;
  - `newData` = 0, `an` = 4'b1110, `seg` = 7'b1000000.
  - `data` = 0 after reset is not a change.

## Timing
- **Acceptance latency:** `data` settles before edge k; `newData` is high in the cycle following edge k+2+`STABLE_CYC`. `hist[0]` and `changeCount` update on that same edge.
- **Display latency:** `seg`/`an` reflect index and `hist` one edge later.
- **Glitch:** any `s2` change inside the stability window restarts `cnt`. A value reverting to `hist[0]` before acceptance yields no pulse.
- **Counter wrap:** `changeCount` 255 → 0 on acceptance; `newData` still pulses.
- **Simultaneous events:** acceptance and scan terminal count on one edge take effect independently.
- **Reset mid-operation:** `sysRst` high at any edge forces all reset values on that edge and suppresses any pending acceptance. Reset dominates every other event.

## Structure
- **Package `data_display_pkg`:** `DIGITS` = 4, the `SEG_0`..`SEG_F` constants, and a `hex_to_seg` function.
- **Sub-module `data_sync_filter`:** synchronizer, stability filter and acceptance logic. Output is `accept` plus the 4-bit value.
- **Top:** history shift register, `changeCount`, prescaler/scanner and output registers.

## Test plan
All scenarios use `SCAN_DIV` = 4, `STABLE_CYC` = 4.
- **Reset:** `sysRst` = 1 for 2 cycles → `an` = 1110, `seg` = 1000000, `changeCount` = 0, `newData` = 0; `an` steps 1101, 1011, 0111, 1110 every 4 cycles.
- **Single change:** `data` 0→3 held → single `newData` pulse after edge k+6, `hist` = {3,0,0,0}, `changeCount` = 1; `seg` = 0110000 while `an` = 1110.
- **Glitch rejection:** `data` 3→5 for 3 cycles, then back to 3 → no `newData`, `changeCount` unchanged.
- **Sequence:** `data` 1, 2, 3, 4, 5, each held 10 cycles → 5 pulses, digits 0..3 show 5, 4, 3, 2 (0010010, 0011001, 0110000, 0100100), `changeCount` = 5.
- **Wrap:** 256 alternating accepted changes → `changeCount` returns to 0 and the last one still pulses `newData`.
- **Reset mid-window:** `sysRst` asserted 2 cycles after a `data` change → no `newData`, all outputs at reset values.
